// File: rtl/line_buff_ctrl_if.sv
// Handshake bundle between the tile line-buffer controller and its
// timing generator / line-buffer pair. master = controller, slave = surroundings.
interface line_buff_ctrl_if #(
  parameter int TILE_CTR_WIDTH = 8,
  parameter int ROW_CTR_WIDTH  = 7
);
  logic                      frame_start_i;
  logic                      line_end_i;
  logic                      disp_active_i;
  logic [9:0]                h_pxl_i;
  logic [1:0]                buff_fill_done_i;
  logic [1:0]                buff_fill_req_o;
  logic [1:0]                buff_sel_o;
  logic [ROW_CTR_WIDTH-1:0]  fill_row_o;
  logic [TILE_CTR_WIDTH-1:0] disp_pxl_id_o;
  logic                      underrun_o;

  modport master (
    input  frame_start_i, line_end_i, disp_active_i, h_pxl_i, buff_fill_done_i,
    output buff_fill_req_o, buff_sel_o, fill_row_o, disp_pxl_id_o, underrun_o
  );

  modport slave (
    output frame_start_i, line_end_i, disp_active_i, h_pxl_i, buff_fill_done_i,
    input  buff_fill_req_o, buff_sel_o, fill_row_o, disp_pxl_id_o, underrun_o
  );
endinterface

// File: rtl/line_buff_ctrl.sv
// Ping-pong tile line-buffer controller: prefetches two tile rows, then swaps
// and refills buffers every TILE_WIDTH lines. Underrun flag under LBUFF_CTRL_UNDERRUN_EN.
module line_buff_ctrl #(
  parameter int WIDTH_PX       = 640,
  parameter int HEIGHT_PX      = 480,
  parameter int TILE_WIDTH     = 4,
  parameter int TILE_CTR_WIDTH = $clog2(WIDTH_PX/TILE_WIDTH),
  parameter int ROW_CTR_WIDTH  = $clog2(HEIGHT_PX/TILE_WIDTH)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  line_buff_ctrl_if.master bus
);

  localparam int TILE_SH = $clog2(TILE_WIDTH);
  localparam int LINE_W  = (TILE_SH < 1) ? 1 : TILE_SH;
  localparam logic [LINE_W-1:0]        LINE_LAST = LINE_W'(TILE_WIDTH-1);
  localparam logic [ROW_CTR_WIDTH-1:0] ROW_LAST  = ROW_CTR_WIDTH'(HEIGHT_PX/TILE_WIDTH-1);
  localparam logic [ROW_CTR_WIDTH:0]   ROWS      = (ROW_CTR_WIDTH+1)'(HEIGHT_PX/TILE_WIDTH);

  typedef enum logic [1:0] {IDLE, PREFILL_A, PREFILL_B, DISPLAY} state_t;

  state_t                   state_q, state_d;
  logic [ROW_CTR_WIDTH-1:0] disp_row_q, disp_row_d;
  logic [LINE_W-1:0]        line_ctr_q, line_ctr_d;
  logic [1:0]               sel_q, sel_d;
  logic [1:0]               req_q, req_d;
  logic [ROW_CTR_WIDTH-1:0] fill_row_q, fill_row_d;
  logic [ROW_CTR_WIDTH:0]   row_plus2;
  logic                     tile_wrap;

  assign row_plus2 = {1'b0, disp_row_q} + (ROW_CTR_WIDTH+1)'(2);
  assign tile_wrap = (state_q == DISPLAY) && bus.line_end_i && !bus.frame_start_i &&
                     (line_ctr_q == LINE_LAST);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      disp_row_q <= '0;
      line_ctr_q <= '0;
      sel_q      <= '0;
      req_q      <= '0;
      fill_row_q <= '0;
    end else begin
      state_q    <= state_d;
      disp_row_q <= disp_row_d;
      line_ctr_q <= line_ctr_d;
      sel_q      <= sel_d;
      req_q      <= req_d;
      fill_row_q <= fill_row_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    disp_row_d = disp_row_q;
    line_ctr_d = line_ctr_q;
    sel_d      = sel_q;
    req_d      = req_q;
    fill_row_d = fill_row_q;
    if (bus.frame_start_i) begin
      state_d    = PREFILL_A;
      disp_row_d = '0;
      line_ctr_d = '0;
      sel_d      = '0;
      req_d      = 2'b01;
      fill_row_d = '0;
    end else begin
      // A done bit only retires a request that is actually outstanding.
      req_d = req_q & ~bus.buff_fill_done_i;
      unique case (state_q)
        PREFILL_A: if (bus.buff_fill_done_i[0] && req_q[0]) begin
          state_d    = PREFILL_B;
          req_d      = 2'b10;
          fill_row_d = ROW_CTR_WIDTH'(1);
        end
        PREFILL_B: if (bus.buff_fill_done_i[1] && req_q[1]) begin
          state_d = DISPLAY;
          sel_d   = 2'b01;
          req_d   = 2'b00;
        end
        DISPLAY: if (bus.line_end_i) begin
          line_ctr_d = line_ctr_q + LINE_W'(1);
          if (tile_wrap) begin
            if (disp_row_q == ROW_LAST) begin
              state_d = IDLE;
              sel_d   = 2'b00;
              req_d   = 2'b00;
            end else begin
              disp_row_d = disp_row_q + ROW_CTR_WIDTH'(1);
              sel_d      = {sel_q[0], sel_q[1]};
              // A still-pending fill keeps the request line; the refill of the
              // released buffer is only issued when nothing is outstanding.
              if (row_plus2 < ROWS && req_d == 2'b00) begin
                req_d      = sel_q;
                fill_row_d = ROW_CTR_WIDTH'(row_plus2);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.buff_fill_req_o = req_q;
  assign bus.buff_sel_o      = sel_q;
  assign bus.fill_row_o      = fill_row_q;
  assign bus.disp_pxl_id_o   = bus.disp_active_i ? TILE_CTR_WIDTH'(bus.h_pxl_i >> TILE_SH)
                                                 : '0;

`ifdef LBUFF_CTRL_UNDERRUN_EN
  logic underrun_q;
  logic underrun_hit;

  // Swapping onto a buffer whose fill has not completed yet.
  assign underrun_hit = tile_wrap && (disp_row_q != ROW_LAST) &&
                        (|(req_q & {sel_q[0], sel_q[1]}));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)           underrun_q <= 1'b0;
    else if (underrun_hit) underrun_q <= 1'b1;
  end

  assign bus.underrun_o = underrun_q;
`else
  assign bus.underrun_o = 1'b0;
`endif

endmodule

// File: doc/line_buff_ctrl.md
LINE_BUFF_CTRL -- requirements
Module: line_buff_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  - WIDTH_PX, 640, active pixels per line.
  - HEIGHT_PX, 480, active lines per frame.
  - TILE_WIDTH, 4, tile width and height in pixels (power of 2).
  - TILE_CTR_WIDTH, $clog2(WIDTH_PX/TILE_WIDTH), tile-column index width.
  - ROW_CTR_WIDTH, $clog2(HEIGHT_PX/TILE_WIDTH), tile-row index width.
REQ-002 Ports SHALL be, one per line:
  - clk_i  in  1  sole clock, rising edge.
  - rstn_i  in  1  reset, asynchronous, active-low.
  - frame_start_i  in  1  one-cycle pulse; begin prefetch for a new frame.
  - line_end_i  in  1  one-cycle pulse at the end of each active pixel line.
  - disp_active_i  in  1  high during active pixels.
  - h_pxl_i  in  10  current pixel column, 0..WIDTH_PX-1.
  - buff_fill_done_i  in  2  per-buffer fill-complete pulse from the line buffers.
  - buff_fill_req_o  out  2  per-buffer fill request, level.
  - buff_sel_o  out  2  one-hot display buffer select; 00 = none.
  - fill_row_o  out  ROW_CTR_WIDTH  tile row to load for the active request.
  - disp_pxl_id_o  out  TILE_CTR_WIDTH  tile column to read.
  - underrun_o  out  1  sticky error flag.

Function
REQ-003 FSM states SHALL be IDLE, PREFILL_A, PREFILL_B, DISPLAY.
REQ-004 frame_start_i in any state SHALL force PREFILL_A next cycle, with all of the following:
  - buff_sel_o=00, buff_fill_req_o=01, fill_row_o=0.
  - display tile row=0, line-in-tile counter=0.
REQ-005 PREFILL_A SHALL, on buff_fill_done_i[0], go to PREFILL_B with buff_fill_req_o=10 and fill_row_o=1.
REQ-006 PREFILL_B SHALL, on buff_fill_done_i[1], go to DISPLAY with buff_sel_o=01 and buff_fill_req_o=00.
REQ-007 A request bit SHALL stay high until its done bit is sampled, then go low on the next clock edge (one-cycle latency); a done bit whose request is low SHALL be ignored.
REQ-008 At most one buff_fill_req_o bit SHALL be high at any time.
REQ-009 In DISPLAY, each line_end_i SHALL increment the 2-bit line-in-tile counter.
REQ-010 When that counter wraps from TILE_WIDTH-1 to 0, the controller SHALL do all of the following:
  - Increment the display tile row.
  - Toggle buff_sel_o (01<->10).
  - If display row+1 < HEIGHT_PX/TILE_WIDTH, request a refill of the buffer just released with fill_row_o = new display row + 1.
REQ-011 On the line_end_i ending tile row HEIGHT_PX/TILE_WIDTH-1 (line 479), the FSM SHALL enter IDLE with buff_sel_o=00 and no request.
REQ-012 disp_pxl_id_o SHALL be h_pxl_i >> log2(TILE_WIDTH) (combinational) when disp_active_i=1, else 0.
REQ-013 Underrun is a buffer swap (REQ-010) while the incoming buffer's request is still high.
  - On underrun, the swap SHALL still occur and underrun_o SHALL set and stay set until reset.
REQ-014 A simultaneous frame_start_i and buff_fill_done_i SHALL resolve in favour of frame_start_i.
REQ-015 line_end_i outside DISPLAY SHALL be ignored.

Reset
REQ-016 While rstn_i=0, all of the following SHALL hold immediately, independent of clk_i:
  - state=IDLE.
  - buff_fill_req_o=00, buff_sel_o=00, fill_row_o=0, underrun_o=0.
  - all counters 0.
REQ-017 Reset asserted mid-fill SHALL drop requests immediately; after release, the block SHALL wait in IDLE for frame_start_i.

Configuration
REQ-018 Macro LBUFF_CTRL_UNDERRUN_EN SHALL control underrun detection.
  - Defined: REQ-013 is implemented.
  - Undefined: detection logic is absent and underrun_o is tied 0.

Verification
REQ-019 Reset then frame_start_i, done[0] after 10 cycles, done[1] after 10 more -> requests go 01, then 10 (fill_row_o=1), then 00; buff_sel_o=01.
REQ-020 In DISPLAY, 4 line_end_i pulses -> buff_sel_o=10, buff_fill_req_o=01, fill_row_o=2; 4 more with done[0] in between -> buff_sel_o=01, req=10, fill_row_o=3.
REQ-021 disp_active_i=1, h_pxl_i=639 -> disp_pxl_id_o=159; disp_active_i=0 -> 0.
REQ-022 Full frame of 480 line_end_i pulses with prompt dones -> IDLE, buff_sel_o=00; no request issued for row 120; underrun_o=0.
REQ-023 Withhold done[0] across the next swap -> underrun_o=1 (macro defined) or 0 (undefined); frame_start_i plus done[1] in the same cycle -> PREFILL_A.
REQ-024 rstn_i low while req=10 -> all outputs 0 without a clock edge; line_end_i pulses are ignored until frame_start_i.
